multicycle_controller: RTL

//  Control FSM for the multi-cycle RV32I core. Sequences the shared ALU, memory

---
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Purpose: control/status bundle between the multi-cycle RV32I controller and its datapath.
// Latency: none, wires only.
// Backpressure: mem_ready from the memory side stalls the controller; master = controller side.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_control, imm_src, reg_write, illegal, state_o
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_control, imm_src, reg_write, illegal, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Purpose: multi-cycle RV32I control FSM; define MC_CTRL_JAL_EN to add JAL support.
// Latency: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles; outputs combinational from state and inputs.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; rst zeroes all outputs.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_e     state_q, state_d;
    logic       bad_alu_q, bad_alu_d;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    always_comb begin
        state_d     = state_q;
        bad_alu_d   = 1'b0;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;

        case (bus.opcode)
            7'b0100011: imm_src = 2'b01;
            7'b1100011: imm_src = 2'b10;
`ifdef MC_CTRL_JAL_EN
            7'b1101111: imm_src = 2'b11;
`endif
            default:    imm_src = 2'b00;
        endcase

        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BEQ;
`ifdef MC_CTRL_JAL_EN
                    7'b1101111:             state_d = S_JAL;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                case (bus.funct3)
                    3'b000:  alu_control = (state_q == S_EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: begin
                        // Remembered so the write-back cycle can drop the register write.
                        illegal   = 1'b1;
                        bad_alu_d = 1'b1;
                    end
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = ~bad_alu_q;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = bus.zero;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            bad_alu_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bad_alu_q <= bad_alu_d;
        end
    end

    // Reset forces every output low immediately, abandoning any in-flight instruction.
    assign bus.pc_write    = pc_write  & ~rst;
    assign bus.adr_src     = adr_src   & ~rst;
    assign bus.mem_write   = mem_write & ~rst;
    assign bus.ir_write    = ir_write  & ~rst;
    assign bus.reg_write   = reg_write & ~rst;
    assign bus.illegal     = illegal   & ~rst;
    assign bus.result_src  = rst ? 2'b00 : result_src;
    assign bus.alu_src_a   = rst ? 2'b00 : alu_src_a;
    assign bus.alu_src_b   = rst ? 2'b00 : alu_src_b;
    assign bus.alu_control = rst ? 3'b000 : alu_control;
    assign bus.imm_src     = rst ? 2'b00 : imm_src;
    assign bus.state_o     = rst ? 4'd0 : state_q;
endmodule
